// File: rtl/debug_unit_ctrl.sv
// rtl/debug_unit_ctrl.sv - host command decoder, imem loader, run/step gate and UART reporter
// Decodes 'L'/'R'/'S' host commands, streams words into imem, gates the pipeline, replies over tx.
module debug_unit_ctrl #(
  parameter int NB_DATA     = 32,
  parameter int NB_ADDRESS  = 32,
  parameter int NB_BYTE     = 8,
  parameter int N_INSTR_MAX = 64,
  parameter int NB_CYCLES   = 32
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [NB_BYTE-1:0]    i_rx_data,
  input  logic                  i_rx_valid,
  output logic [NB_BYTE-1:0]    o_tx_data,
  output logic                  o_tx_start,
  input  logic                  i_tx_busy,
  output logic                  o_imem_wr_en,
  output logic [NB_ADDRESS-1:0] o_imem_wr_addr,
  output logic [NB_DATA-1:0]    o_imem_wr_data,
  output logic                  o_pipe_en,
  output logic                  o_pipe_reset,
  input  logic                  i_halt,
  input  logic [NB_ADDRESS-1:0] i_pc,
  output logic [2:0]            o_state
);

  localparam int NB_IDX = $clog2(N_INSTR_MAX + 1);
  localparam logic [NB_IDX-1:0]    IDX_ONE = 1;
  localparam logic [NB_CYCLES-1:0] CYC_ONE = 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD_CNT  = 3'd1,
    ST_LOAD_BYTE = 3'd2,
    ST_RUN       = 3'd3,
    ST_STEP      = 3'd4,
    ST_SEND      = 3'd5,
    ST_SEND_WAIT = 3'd6
  } state_t;

  state_t state, state_next;

  logic [NB_IDX-1:0]    n_words;
  logic [NB_IDX-1:0]    word_idx;
  logic [1:0]           byte_cnt;
  logic [NB_DATA-9:0]   word_sr;
  logic [NB_CYCLES-1:0] cycles;
  logic [31:0]          pc_q;
  logic [7:0]           resp;
  logic                 is_report;
  logic [2:0]           idx;
  logic                 seen_busy;

  logic       n_bad;
  logic       last_word;
  logic       tx_last;
  logic       enter_report;
  logic [63:0] rpt;
  logic [5:0]  sh;
  logic [7:0]  cur_byte;

  assign n_bad     = (i_rx_data == '0) || (int'(i_rx_data) > N_INSTR_MAX);
  assign last_word = (word_idx + IDX_ONE) == n_words;
  assign tx_last   = is_report ? (idx == 3'd7) : 1'b1;
  assign o_pipe_en = ((state == ST_RUN) && !i_halt) || (state == ST_STEP);
  assign o_state   = state;

  // Report is PC then cycle count, each 32 bits, sent most significant byte first.
  assign rpt      = {pc_q, 32'(cycles)};
  assign sh       = {3'd7 - idx, 3'b000};
  assign cur_byte = is_report ? rpt[sh +: 8] : resp;

  assign enter_report = (state_next == ST_SEND) &&
                        ((state == ST_IDLE) || (state == ST_RUN) || (state == ST_STEP));

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            8'h4C:   state_next = ST_LOAD_CNT;
            8'h52:   state_next = i_halt ? ST_SEND : ST_RUN;
            8'h53:   state_next = i_halt ? ST_SEND : ST_STEP;
            default: state_next = ST_IDLE;
          endcase
        end
      end
      ST_LOAD_CNT: begin
        if (i_rx_valid) state_next = n_bad ? ST_SEND : ST_LOAD_BYTE;
      end
      ST_LOAD_BYTE: begin
        if (i_rx_valid && (byte_cnt == 2'd3) && last_word) state_next = ST_SEND;
      end
      ST_RUN: begin
        if (i_halt) state_next = ST_SEND;
      end
      ST_STEP: state_next = ST_SEND;
      ST_SEND: begin
        if (!i_tx_busy) state_next = ST_SEND_WAIT;
      end
      ST_SEND_WAIT: begin
        if (seen_busy && !i_tx_busy) state_next = tx_last ? ST_IDLE : ST_SEND;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      o_tx_data      <= '0;
      o_tx_start     <= 1'b0;
      o_imem_wr_en   <= 1'b0;
      o_imem_wr_addr <= '0;
      o_imem_wr_data <= '0;
      o_pipe_reset   <= 1'b0;
      n_words        <= '0;
      word_idx       <= '0;
      byte_cnt       <= '0;
      word_sr        <= '0;
      cycles         <= '0;
      pc_q           <= '0;
      resp           <= '0;
      is_report      <= 1'b0;
      idx            <= '0;
      seen_busy      <= 1'b0;
    end else begin
      o_imem_wr_en <= 1'b0;
      o_pipe_reset <= 1'b0;
      o_tx_start   <= 1'b0;

      if (o_pipe_en && (cycles != '1)) cycles <= cycles + CYC_ONE;

      case (state)
        ST_IDLE: begin
          if (i_rx_valid && (i_rx_data == 8'h4C)) begin
            o_pipe_reset <= 1'b1;
            cycles       <= '0;
          end
        end
        ST_LOAD_CNT: begin
          if (i_rx_valid) begin
            if (n_bad) begin
              resp      <= 8'hEE;
              is_report <= 1'b0;
              idx       <= '0;
            end else begin
              n_words  <= NB_IDX'(i_rx_data);
              word_idx <= '0;
              byte_cnt <= '0;
            end
          end
        end
        ST_LOAD_BYTE: begin
          if (i_rx_valid) begin
            word_sr  <= {word_sr[NB_DATA-17:0], i_rx_data};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              o_imem_wr_en   <= 1'b1;
              o_imem_wr_addr <= NB_ADDRESS'({word_idx, 2'b00});
              o_imem_wr_data <= {word_sr, i_rx_data};
              word_idx       <= word_idx + IDX_ONE;
              if (last_word) begin
                resp      <= 8'h4B;
                is_report <= 1'b0;
                idx       <= '0;
              end
            end
          end
        end
        ST_SEND: begin
          if (!i_tx_busy) begin
            o_tx_data  <= NB_BYTE'(cur_byte);
            o_tx_start <= 1'b1;
            seen_busy  <= 1'b0;
          end
        end
        ST_SEND_WAIT: begin
          if (i_tx_busy)      seen_busy <= 1'b1;
          else if (seen_busy) idx       <= idx + 3'd1;
        end
        default: ;
      endcase

      // PC is captured as the report is queued so later PC motion cannot skew it.
      if (enter_report) begin
        pc_q      <= 32'(i_pc);
        is_report <= 1'b1;
        idx       <= '0;
      end
    end
  end

endmodule

// File: tb/tb_debug_unit_ctrl.sv
// tb/tb_debug_unit_ctrl.sv - directed self-checking bench for debug_unit_ctrl
// Load, error, step, run, halt-held and mid-load reset sequences with a simple tx responder.
module tb_debug_unit_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        ext_busy = 1'b0;
  logic        model_busy = 1'b0;
  logic        tx_busy;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        pipe_en;
  logic        pipe_reset;
  logic        halt;
  logic [31:0] pc;
  logic [2:0]  state;

  int n_pass  = 0;
  int n_total = 0;
  int en_cnt  = 0;
  int rst_cnt = 0;
  int wr_cnt  = 0;
  logic [31:0] wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  logic [7:0]  tx_q[$];

  assign tx_busy = ext_busy | model_busy;

  always #5 clk = ~clk;

  debug_unit_ctrl dut (
    .i_clk          (clk),
    .i_reset        (rst_n),
    .i_rx_data      (rx_data),
    .i_rx_valid     (rx_valid),
    .o_tx_data      (tx_data),
    .o_tx_start     (tx_start),
    .i_tx_busy      (tx_busy),
    .o_imem_wr_en   (wr_en),
    .o_imem_wr_addr (wr_addr),
    .o_imem_wr_data (wr_data),
    .o_pipe_en      (pipe_en),
    .o_pipe_reset   (pipe_reset),
    .i_halt         (halt),
    .i_pc           (pc),
    .o_state        (state)
  );

  initial begin
    forever begin
      @(negedge clk);
      if (pipe_en)    en_cnt++;
      if (pipe_reset) rst_cnt++;
      if (wr_en) begin
        wr_cnt++;
        wr_addr_q.push_back(wr_addr);
        wr_data_q.push_back(wr_data);
      end
    end
  end

  // UART transmitter stand-in: busy rises the cycle after start and holds three cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_start) begin
        tx_q.push_back(tx_data);
        @(posedge clk);
        #1 model_busy = 1'b1;
        repeat (3) @(posedge clk);
        #1 model_busy = 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #1 rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1 rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (state == 3'd0) break;
    end
    chk(tag, {61'd0, state}, 64'd0);
  endtask

  function automatic logic [63:0] tx_packed();
    logic [63:0] v = '0;
    foreach (tx_q[i]) v = {v[55:0], tx_q[i]};
    return v;
  endfunction

  task automatic chk_report(input string tag, input logic [31:0] exp_pc, input logic [31:0] exp_cnt);
    chk({tag, "_len"}, 64'(tx_q.size()), 64'd8);
    chk({tag, "_bytes"}, tx_packed(), {exp_pc, exp_cnt});
  endtask

  task automatic chk_byte(input string tag, input logic [7:0] exp);
    chk({tag, "_len"}, 64'(tx_q.size()), 64'd1);
    chk({tag, "_byte"}, tx_packed(), 64'(exp));
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    halt     = 1'b0;
    pc       = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", {61'd0, state}, 64'd0);
    chk("rst_outs", {59'd0, tx_start, wr_en, pipe_en, pipe_reset, 1'b0}, 64'd0);
    chk("rst_tx_data", 64'(tx_data), 64'd0);
    chk("rst_wr", {wr_addr, wr_data}, 64'd0);
    rst_n = 1'b1;

    // two-word load
    tx_q.delete();
    send(8'h4C); send(8'h02);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD);
    wait_idle("load_idle");
    chk("load_pipe_reset", 64'(rst_cnt), 64'd1);
    chk("load_wr_cnt", 64'(wr_cnt), 64'd2);
    chk("load_wr0", {wr_addr_q[0], wr_data_q[0]}, {32'h0, 32'h11223344});
    chk("load_wr1", {wr_addr_q[1], wr_data_q[1]}, {32'h4, 32'hAABBCCDD});
    chk_byte("load_ack", 8'h4B);

    // bad word counts: 0 and 65
    tx_q.delete();
    send(8'h4C); send(8'h00);
    wait_idle("n0_idle");
    chk_byte("n0_err", 8'hEE);
    tx_q.delete();
    send(8'h4C); send(8'h41);
    wait_idle("n65_idle");
    chk_byte("n65_err", 8'hEE);
    chk("bad_n_no_wr", 64'(wr_cnt), 64'd2);

    // ignored byte in IDLE
    tx_q.delete();
    send(8'h00);
    repeat (5) @(negedge clk);
    chk("ignore_state", {61'd0, state}, 64'd0);
    chk("ignore_no_tx", 64'(tx_q.size()), 64'd0);

    // single step
    pc = 32'h4;
    en_cnt = 0;
    tx_q.delete();
    send(8'h53);
    wait_idle("step_idle");
    chk("step_en", 64'(en_cnt), 64'd1);
    chk_report("step_rpt", 32'h4, 32'h1);

    // run, halt after ten enabled cycles
    pc = 32'h100;
    en_cnt = 0;
    tx_q.delete();
    send(8'h52);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      #1;
      if (en_cnt == 10) break;
    end
    @(posedge clk);
    #1 halt = 1'b1;
    #1 chk("run_halt_drop", {63'd0, pipe_en}, 64'd0);
    wait_idle("run_idle");
    chk("run_en", 64'(en_cnt), 64'd10);
    chk_report("run_rpt", 32'h100, 32'd11);

    // halt already set, tx held busy for 100 cycles
    en_cnt = 0;
    tx_q.delete();
    ext_busy = 1'b1;
    send(8'h53);
    repeat (50) @(negedge clk);
    chk("busy_hold_state", {61'd0, state}, 64'd5);
    chk("busy_hold_no_tx", 64'(tx_q.size()), 64'd0);
    repeat (50) @(negedge clk);
    ext_busy = 1'b0;
    wait_idle("halt_step_idle");
    chk("halt_step_en", 64'(en_cnt), 64'd0);
    chk_report("halt_step_rpt", 32'h100, 32'd11);
    tx_q.delete();
    send(8'h52);
    wait_idle("halt_run_idle");
    chk("halt_run_en", 64'(en_cnt), 64'd0);
    chk_report("halt_run_rpt", 32'h100, 32'd11);
    halt = 1'b0;

    // reset mid-word with the maximum count of 64
    wr_cnt = 0;
    send(8'h4C); send(8'h40);
    send(8'h11); send(8'h22);
    chk("max_n_loading", {61'd0, state}, 64'd2);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_state", {61'd0, state}, 64'd0);
    chk("midrst_outs", {60'd0, tx_start, wr_en, pipe_en, pipe_reset}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("midrst_no_wr", 64'(wr_cnt), 64'd0);
    pc = 32'h4;
    en_cnt = 0;
    tx_q.delete();
    send(8'h53);
    wait_idle("post_rst_idle");
    chk("post_rst_en", 64'(en_cnt), 64'd1);
    chk_report("post_rst_rpt", 32'h4, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
